// File: rtl/cpu19_pkg.sv
// Shared constants for the cpu19 core: word/PC widths, instruction field
// positions, opcode encodings and the ENC/DCR rotate helpers.
package cpu19_pkg;

  localparam int unsigned XLEN = 19;
  localparam int unsigned PCW  = 14;

  localparam int unsigned OP_HI  = 18;
  localparam int unsigned OP_LO  = 14;
  localparam int unsigned RD_HI  = 13;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS1_HI = 9;
  localparam int unsigned RS1_LO = 6;
  localparam int unsigned RS2_HI = 5;
  localparam int unsigned RS2_LO = 2;
  localparam int unsigned IMM_HI = 9;
  localparam int unsigned BT_HI  = 5;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [PCW-1:0]  pc_t;
  typedef logic [4:0]      opcode_t;

  localparam opcode_t OP_ADD  = 5'b00000;
  localparam opcode_t OP_SUB  = 5'b00001;
  localparam opcode_t OP_MUL  = 5'b00010;
  localparam opcode_t OP_DIV  = 5'b00011;
  localparam opcode_t OP_INC  = 5'b00100;
  localparam opcode_t OP_DEC  = 5'b00101;
  localparam opcode_t OP_AND  = 5'b00110;
  localparam opcode_t OP_OR   = 5'b00111;
  localparam opcode_t OP_XOR  = 5'b01000;
  localparam opcode_t OP_NOT  = 5'b01001;
  localparam opcode_t OP_JMP  = 5'b01010;
  localparam opcode_t OP_BEQ  = 5'b01011;
  localparam opcode_t OP_BNE  = 5'b01100;
  localparam opcode_t OP_CALL = 5'b01101;
  localparam opcode_t OP_RET  = 5'b01110;
  localparam opcode_t OP_LD   = 5'b01111;
  localparam opcode_t OP_ENC  = 5'b10000;
  localparam opcode_t OP_DCR  = 5'b10001;
  localparam opcode_t OP_ST   = 5'b10010;
  localparam opcode_t OP_LDI  = 5'b10011;

  function automatic word_t rotl3(input word_t x);
    return {x[XLEN-4:0], x[XLEN-1:XLEN-3]};
  endfunction

  function automatic word_t rotr3(input word_t x);
    return {x[2:0], x[XLEN-1:3]};
  endfunction

endpackage

// File: rtl/cpu19_alu.sv
// Combinational ALU for cpu19: produces the rd write value for ADD..DCR.
module cpu19_alu
  import cpu19_pkg::*;
#(
  parameter logic [XLEN-1:0] KEY = 19'h5A5A5
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] d_old_i,
  output logic [XLEN-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_SUB: y_o = a_i - b_i;
      OP_MUL: y_o = a_i * b_i;
      // Divide by zero saturates to all ones rather than trapping.
      OP_DIV: y_o = (b_i == '0) ? '1 : a_i / b_i;
      OP_INC: y_o = d_old_i + XLEN'(1);
      OP_DEC: y_o = d_old_i - XLEN'(1);
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_NOT: y_o = ~d_old_i;
      OP_ENC: y_o = rotl3(a_i ^ KEY);
      OP_DCR: y_o = rotr3(a_i) ^ KEY;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu19.sv
// Single-cycle 19-bit register-machine core: one instruction per rising edge,
// architectural effect reported on the registered result bus.
module cpu19
  import cpu19_pkg::*;
#(
  parameter int unsigned     DMEM_DEPTH  = 64,
  parameter int unsigned     STACK_DEPTH = 8,
  parameter logic [XLEN-1:0] KEY         = 19'h5A5A5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AW  = $clog2(DMEM_DEPTH);
  localparam int unsigned SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  word_t          rf_q  [16];
  word_t          mem_q [DMEM_DEPTH];
  pc_t            stk_q [STACK_DEPTH];
  pc_t            pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  word_t          result_q, result_d;

  opcode_t        op;
  logic [3:0]     rd, rs1, rs2;
  logic [AW-1:0]  addr;
  word_t          rd_val, rs1_val, rs2_val, alu_y;
  pc_t            pc_inc;
  logic [SPW-1:0] sp_inc, sp_dec;

  logic           rf_we, mem_we, stk_we;
  word_t          rf_wd;

  assign op      = instruction[OP_HI:OP_LO];
  assign rd      = instruction[RD_HI:RD_LO];
  assign rs1     = instruction[RS1_HI:RS1_LO];
  assign rs2     = instruction[RS2_HI:RS2_LO];
  assign addr    = instruction[AW-1:0];

  assign rd_val  = rf_q[rd];
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  assign pc_inc  = pc_q + PCW'(1);

  // Explicit wrap keeps the stack circular even for non power-of-two depths.
  assign sp_inc  = (sp_q == SPW'(STACK_DEPTH - 1)) ? '0 : sp_q + SPW'(1);
  assign sp_dec  = (sp_q == '0) ? SPW'(STACK_DEPTH - 1) : sp_q - SPW'(1);

  cpu19_alu #(
    .KEY (KEY)
  ) u_alu (
    .op_i    (op),
    .a_i     (rs1_val),
    .b_i     (rs2_val),
    .d_old_i (rd_val),
    .y_o     (alu_y)
  );

  always_comb begin
    pc_d     = pc_inc;
    sp_d     = sp_q;
    result_d = result_q;
    rf_we    = 1'b0;
    rf_wd    = alu_y;
    mem_we   = 1'b0;
    stk_we   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ENC, OP_DCR: begin
        rf_we    = 1'b1;
        rf_wd    = alu_y;
        result_d = alu_y;
      end
      OP_LDI: begin
        rf_we    = 1'b1;
        rf_wd    = word_t'(instruction[IMM_HI:0]);
        result_d = word_t'(instruction[IMM_HI:0]);
      end
      OP_JMP: begin
        pc_d     = instruction[PCW-1:0];
        result_d = word_t'(pc_d);
      end
      // Branches compare the rd/rs1 field positions, not rs1/rs2.
      OP_BEQ: begin
        if (rd_val == rs1_val) pc_d = PCW'(instruction[BT_HI:0]);
        result_d = word_t'(pc_d);
      end
      OP_BNE: begin
        if (rd_val != rs1_val) pc_d = PCW'(instruction[BT_HI:0]);
        result_d = word_t'(pc_d);
      end
      OP_CALL: begin
        stk_we   = 1'b1;
        sp_d     = sp_inc;
        pc_d     = instruction[PCW-1:0];
        result_d = word_t'(pc_d);
      end
      OP_RET: begin
        sp_d     = sp_dec;
        pc_d     = stk_q[sp_dec];
        result_d = word_t'(pc_d);
      end
      OP_LD: begin
        rf_we    = 1'b1;
        rf_wd    = mem_q[addr];
        result_d = mem_q[addr];
      end
      OP_ST: begin
        mem_we   = 1'b1;
        result_d = rd_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      sp_q     <= '0;
      result_q <= '0;
      rf_q     <= '{default: '0};
      mem_q    <= '{default: '0};
      stk_q    <= '{default: '0};
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      result_q <= result_d;
      if (rf_we)  rf_q[rd]    <= rf_wd;
      if (mem_we) mem_q[addr] <= rd_val;
      if (stk_we) stk_q[sp_q] <= pc_inc;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_cpu19.sv
// Testbench for cpu19: table of {instruction, expected result} vectors plus
// hand sequences for mid-run reset and call-stack wrap, via a result scoreboard.
module tb_cpu19;
  import cpu19_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] instruction;
  logic [18:0] result;

  cpu19 #(
    .DMEM_DEPTH  (64),
    .STACK_DEPTH (8),
    .KEY         (19'h5A5A5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .result      (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] instr;
    logic [18:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [13:0] mstk[8];
  int          msp;
  logic [13:0] mpc;

  function automatic logic [18:0] rt(logic [4:0] op, logic [3:0] d, logic [3:0] s1, logic [3:0] s2);
    return {op, d, s1, s2, 2'b00};
  endfunction

  function automatic logic [18:0] it(logic [4:0] op, logic [3:0] d, logic [9:0] imm);
    return {op, d, imm};
  endfunction

  function automatic logic [18:0] jt(logic [4:0] op, logic [13:0] a);
    return {op, a};
  endfunction

  function automatic logic [18:0] bt(logic [4:0] op, logic [3:0] a, logic [3:0] b, logic [5:0] t);
    return {op, a, b, t};
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: result=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic [18:0] instr, input logic [18:0] exp, input string name);
    logic [18:0] e;
    string       n;
    @(negedge clk);
    instruction = instr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: result=%h expected=<queued value>", result);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, result, e);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    instruction = it(OP_LDI, 4'd1, 10'd5);
    @(posedge clk);
    #1;
    check(name, result, 19'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mstk[i] = '0;
    msp = 0;
    mpc = '0;
  endtask

  task automatic model_call(input logic [13:0] target, input string name);
    mstk[msp] = mpc + 14'd1;
    msp = (msp + 1) % 8;
    mpc = target;
    step(jt(OP_CALL, target), {5'b0, target}, name);
  endtask

  task automatic model_ret(input string name);
    msp = (msp + 7) % 8;
    mpc = mstk[msp];
    step(jt(OP_RET, 14'd0), {5'b0, mpc}, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: result=%h expected=<run to finish>", result);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Comments give the PC the instruction executes at.
    vecs.push_back('{it(OP_LDI, 4'd1, 10'd2),        19'd2});      // 0
    vecs.push_back('{it(OP_LDI, 4'd2, 10'd12),       19'd12});     // 1
    vecs.push_back('{rt(OP_ADD, 4'd0, 4'd1, 4'd2),   19'd14});     // 2
    vecs.push_back('{it(OP_LDI, 4'd4, 10'd10),       19'd10});     // 3
    vecs.push_back('{it(OP_LDI, 4'd5, 10'd2),        19'd2});      // 4
    vecs.push_back('{rt(OP_SUB, 4'd3, 4'd4, 4'd5),   19'd8});      // 5
    vecs.push_back('{rt(OP_SUB, 4'd3, 4'd5, 4'd4),   19'h7FFF8});  // 6
    vecs.push_back('{it(OP_LDI, 4'd6, 10'd3),        19'd3});      // 7
    vecs.push_back('{it(OP_LDI, 4'd7, 10'd8),        19'd8});      // 8
    vecs.push_back('{rt(OP_MUL, 4'd8, 4'd6, 4'd7),   19'd24});     // 9
    vecs.push_back('{rt(OP_DIV, 4'd9, 4'd4, 4'd5),   19'd5});      // 10
    vecs.push_back('{it(OP_LDI, 4'd10, 10'd0),       19'd0});      // 11
    vecs.push_back('{rt(OP_DIV, 4'd9, 4'd4, 4'd10),  19'h7FFFF});  // 12
    vecs.push_back('{it(OP_LDI, 4'd12, 10'd10),      19'd10});     // 13
    vecs.push_back('{rt(OP_INC, 4'd12, 4'd0, 4'd0),  19'd11});     // 14
    vecs.push_back('{it(OP_LDI, 4'd13, 10'd20),      19'd20});     // 15
    vecs.push_back('{rt(OP_DEC, 4'd13, 4'd0, 4'd0),  19'd19});     // 16
    vecs.push_back('{it(OP_LDI, 4'd15, 10'd2),       19'd2});      // 17
    vecs.push_back('{it(OP_LDI, 4'd1, 10'd4),        19'd4});      // 18
    vecs.push_back('{rt(OP_AND, 4'd11, 4'd15, 4'd1), 19'd0});      // 19
    vecs.push_back('{rt(OP_OR,  4'd11, 4'd15, 4'd1), 19'd6});      // 20
    vecs.push_back('{rt(OP_XOR, 4'd11, 4'd15, 4'd1), 19'd6});      // 21
    vecs.push_back('{it(OP_LDI, 4'd14, 10'd4),       19'd4});      // 22
    vecs.push_back('{rt(OP_NOT, 4'd14, 4'd0, 4'd0),  19'h7FFFB});  // 23
    vecs.push_back('{jt(OP_JMP, 14'd18),             19'd18});     // 24
    vecs.push_back('{it(OP_LDI, 4'd1, 10'd10),       19'd10});     // 18
    vecs.push_back('{it(OP_LDI, 4'd2, 10'd10),       19'd10});     // 19
    vecs.push_back('{bt(OP_BEQ, 4'd1, 4'd2, 6'd5),   19'd5});      // 20 taken
    vecs.push_back('{bt(OP_BNE, 4'd1, 4'd2, 6'd9),   19'd6});      // 5 not taken
    vecs.push_back('{jt(OP_CALL, 14'd50),            19'd50});     // 6
    vecs.push_back('{jt(OP_RET, 14'd0),              19'd7});      // 50
    vecs.push_back('{bt(OP_BEQ, 4'd1, 4'd0, 6'd9),   19'd8});      // 7 not taken
    vecs.push_back('{bt(OP_BNE, 4'd1, 4'd0, 6'd30),  19'd30});     // 8 taken
    vecs.push_back('{it(OP_LDI, 4'd2, 10'd3),        19'd3});      // 30
    vecs.push_back('{it(OP_ST,  4'd2, 10'd62),       19'd3});      // 31
    vecs.push_back('{it(OP_LD,  4'd5, 10'd62),       19'd3});      // 32
    vecs.push_back('{rt(OP_ADD, 4'd6, 4'd5, 4'd0),   19'd17});     // 33
    vecs.push_back('{it(OP_LDI, 4'd3, 10'd617),      19'd617});    // 34
    vecs.push_back('{rt(OP_ADD, 4'd3, 4'd3, 4'd3),   19'd1234});   // 35
    vecs.push_back('{rt(OP_ENC, 4'd2, 4'd3, 4'd0),   19'h50BBD});  // 36
    vecs.push_back('{rt(OP_DCR, 4'd4, 4'd2, 4'd0),   19'd1234});   // 37
    vecs.push_back('{jt(5'b10100, 14'h3FFF),         19'd1234});   // 38 NOP holds
    vecs.push_back('{jt(OP_JMP, 14'h3FFF),           19'h03FFF});  // 39
    vecs.push_back('{it(OP_LDI, 4'd7, 10'd1),        19'd1});      // 3FFF, wraps
    vecs.push_back('{bt(OP_BEQ, 4'd1, 4'd0, 6'd9),   19'd1});      // 0 not taken

    rst = 1'b1;
    instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", result, 19'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].instr, vecs[i].exp, $sformatf("vec%0d", i));

    do_reset("mid_reset");
    model_ret("ret_empty");
    for (int r = 0; r < 16; r++) begin
      step(it(OP_ST, 4'(r), 10'(r)), 19'd0, $sformatf("rst_reg%0d", r));
      mpc = mpc + 14'd1;
    end
    step(it(OP_LD, 4'd1, 10'd62), 19'd0, "rst_mem");
    mpc = mpc + 14'd1;

    for (int i = 0; i < 9; i++) model_call(14'(100 + i), $sformatf("call%0d", i));
    for (int i = 0; i < 9; i++) model_ret($sformatf("ret%0d", i));

    @(negedge clk);
    instruction = jt(5'b11111, 14'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
